// File: rtl/se_fu.sv
// se_fu: secure-execution functional unit, 2-stage valid/ready pipeline.
// Ports: clk, reset_n, in_* instruction handshake, out_* encrypted result.
module se_fu #(
    parameter logic [127:0] KEY = 128'h0123456789ABCDEF_FEDCBA9876543210
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_inst,
    input  logic [127:0] in_op1,
    input  logic         in_op1_is_a_byte,
    input  logic         in_op1_encrypted,
    input  logic [127:0] in_op2,
    input  logic         in_op2_is_a_byte,
    input  logic         in_op2_encrypted,
    input  logic [127:0] in_cond,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_result
);

    typedef enum logic [7:0] {
        OP_ADD  = 8'h00,
        OP_SUB  = 8'h01,
        OP_MUL  = 8'h02,
        OP_AND  = 8'h03,
        OP_OR   = 8'h04,
        OP_XOR  = 8'h05,
        OP_SHL  = 8'h06,
        OP_SHR  = 8'h07,
        OP_EQ   = 8'h08,
        OP_LTU  = 8'h09,
        OP_CMOV = 8'h0A
    } op_e;

    logic         s1_valid_q;
    logic [7:0]   s1_op_q;
    logic [127:0] s1_a_q;
    logic [127:0] s1_b_q;
    logic [127:0] s1_cond_q;

    logic         out_valid_q;
    logic [127:0] out_result_q;

    logic         s1_adv;
    logic         s2_adv;
    logic         s1_load;

    logic [127:0] a_d;
    logic [127:0] b_d;
    logic [127:0] raw;

    // Decrypt first, then truncate to a byte.
    function automatic logic [127:0] prep(
        input logic [127:0] x,
        input logic         is_byte,
        input logic         enc
    );
        logic [127:0] y;
        y = enc ? (x ^ KEY) : x;
        if (is_byte) begin
            y = {120'b0, y[7:0]};
        end
        return y;
    endfunction

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = s1_adv && in_valid;

    assign a_d = prep(in_op1, in_op1_is_a_byte, in_op1_encrypted);
    assign b_d = prep(in_op2, in_op2_is_a_byte, in_op2_encrypted);

    always_comb begin
        raw = '0;
        case (s1_op_q)
            OP_ADD:  raw = s1_a_q + s1_b_q;
            OP_SUB:  raw = s1_a_q - s1_b_q;
            OP_MUL:  raw = {64'b0, s1_a_q[63:0]} * {64'b0, s1_b_q[63:0]};
            OP_AND:  raw = s1_a_q & s1_b_q;
            OP_OR:   raw = s1_a_q | s1_b_q;
            OP_XOR:  raw = s1_a_q ^ s1_b_q;
            OP_SHL:  raw = s1_a_q << s1_b_q[6:0];
            OP_SHR:  raw = s1_a_q >> s1_b_q[6:0];
            OP_EQ:   raw = {127'b0, s1_a_q == s1_b_q};
            OP_LTU:  raw = {127'b0, s1_a_q < s1_b_q};
            // Condition word is tested raw, never decrypted.
            OP_CMOV: raw = (s1_cond_q != '0) ? s1_a_q : s1_b_q;
            default: raw = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cond_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (s1_load) begin
                s1_op_q   <= in_inst;
                s1_a_q    <= a_d;
                s1_b_q    <= b_d;
                s1_cond_q <= in_cond;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_result_q <= raw ^ KEY;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule

// File: tb/tb_se_fu.sv
// tb_se_fu: directed vector table plus backpressure and reset sequences
// for se_fu.
module tb_se_fu;

    localparam logic [127:0] KEY = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam int NV = 18;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_inst = '0;
    logic [127:0] in_op1 = '0;
    logic         in_op1_is_a_byte = 1'b0;
    logic         in_op1_encrypted = 1'b0;
    logic [127:0] in_op2 = '0;
    logic         in_op2_is_a_byte = 1'b0;
    logic         in_op2_encrypted = 1'b0;
    logic [127:0] in_cond = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_result;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0]   inst;
        logic [127:0] a;
        logic         a_byte;
        logic         a_enc;
        logic [127:0] b;
        logic         b_byte;
        logic         b_enc;
        logic [127:0] cond;
        logic [127:0] exp_raw;
    } vec_t;

    vec_t v[NV];

    se_fu #(.KEY(KEY)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_inst          (in_inst),
        .in_op1           (in_op1),
        .in_op1_is_a_byte (in_op1_is_a_byte),
        .in_op1_encrypted (in_op1_encrypted),
        .in_op2           (in_op2),
        .in_op2_is_a_byte (in_op2_is_a_byte),
        .in_op2_encrypted (in_op2_encrypted),
        .in_cond          (in_cond),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [7:0] inst, input logic [127:0] a,
        input logic ab, input logic ae, input logic [127:0] b,
        input logic bb, input logic be, input logic [127:0] c,
        input logic [127:0] r
    );
        vec_t t;
        t.inst = inst; t.a = a; t.a_byte = ab; t.a_enc = ae;
        t.b = b; t.b_byte = bb; t.b_enc = be; t.cond = c;
        t.exp_raw = r;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        in_inst          = t.inst;
        in_op1           = t.a;
        in_op1_is_a_byte = t.a_byte;
        in_op1_encrypted = t.a_enc;
        in_op2           = t.b;
        in_op2_is_a_byte = t.b_byte;
        in_op2_encrypted = t.b_enc;
        in_cond          = t.cond;
        in_valid         = 1'b1;
    endtask

    initial begin
        logic [127:0] ones;
        logic [127:0] top;
        vec_t va, vb, vc;
        ones = '1;
        top  = 128'd1 << 127;

        v[0]  = mk(8'h00, 5, 0, 0, 3, 0, 0, 0, 8);
        v[1]  = mk(8'h01, 128'd10 ^ KEY, 0, 1, 3, 0, 0, 0, 7);
        v[2]  = mk(8'h02, 128'h1FF, 1, 0, 2, 0, 0, 0, 128'h1FE);
        v[3]  = mk(8'h0A, 1, 0, 0, 2, 0, 0, 0, 2);
        v[4]  = mk(8'h0A, 1, 0, 0, 2, 0, 0, 1, 1);
        v[5]  = mk(8'h01, 0, 0, 0, 1, 0, 0, 0, ones);
        v[6]  = mk(8'h06, 1, 0, 0, 127, 0, 0, 0, top);
        v[7]  = mk(8'hFF, 5, 0, 0, 3, 0, 0, 0, 0);
        v[8]  = mk(8'h03, 128'hF0F0, 0, 0, 128'hFF00, 0, 0, 0, 128'hF000);
        v[9]  = mk(8'h04, 128'hF0F0, 0, 0, 128'hFF00, 0, 0, 0, 128'hFFF0);
        v[10] = mk(8'h05, 128'hF0F0, 0, 0, 128'hFF00, 0, 0, 0, 128'h0FF0);
        v[11] = mk(8'h07, top, 0, 0, 127, 0, 0, 0, 1);
        v[12] = mk(8'h08, 7, 0, 0, 7, 0, 0, 0, 1);
        v[13] = mk(8'h08, 7, 0, 0, 8, 0, 0, 0, 0);
        v[14] = mk(8'h09, 3, 0, 0, 4, 0, 0, 0, 1);
        v[15] = mk(8'h09, ones, 0, 0, 3, 0, 0, 0, 0);
        v[16] = mk(8'h02, {64'h1, 64'h2}, 0, 0, 3, 0, 0, 0, 6);
        v[17] = mk(8'h00, 1, 0, 0, 128'h1234 ^ KEY, 1, 1, top, 128'h35);

        // Reset state
        #2;
        chk("rst_out_valid", {127'b0, out_valid}, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_in_ready", {127'b0, in_ready}, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {127'b0, in_ready}, 1);

        // Table vectors, one at a time, consumer always ready
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(v[i]);
            chk($sformatf("v%0d_in_ready", i), {127'b0, in_ready}, 1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {127'b0, out_valid}, 1);
            chk($sformatf("v%0d_result", i), out_result,
                v[i].exp_raw ^ KEY);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_drop", i), {127'b0, out_valid}, 0);
        end

        // Backpressure: three back-to-back with consumer stalled
        va = mk(8'h00, 100, 0, 0, 1, 0, 0, 0, 0);
        vb = mk(8'h00, 200, 0, 0, 2, 0, 0, 0, 0);
        vc = mk(8'h00, 300, 0, 0, 3, 0, 0, 0, 0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(va);
        chk("bp_a_ready", {127'b0, in_ready}, 1);
        @(posedge clk);
        #1 drive(vb);
        chk("bp_b_ready", {127'b0, in_ready}, 1);
        @(posedge clk);
        #1 drive(vc);
        @(negedge clk);
        chk("bp_c_blocked", {127'b0, in_ready}, 0);
        chk("bp_hold_valid", {127'b0, out_valid}, 1);
        chk("bp_hold_a", out_result, 128'd101 ^ KEY);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_still_a", out_result, 128'd101 ^ KEY);
        chk("bp_still_blocked", {127'b0, in_ready}, 0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {127'b0, in_ready}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_drain_b", out_result, 128'd202 ^ KEY);
        chk("bp_drain_b_v", {127'b0, out_valid}, 1);
        @(posedge clk);
        #1;
        chk("bp_drain_c", out_result, 128'd303 ^ KEY);
        chk("bp_drain_c_v", {127'b0, out_valid}, 1);
        @(posedge clk);
        #1;
        chk("bp_empty", {127'b0, out_valid}, 0);

        // Asynchronous reset with a held result
        @(negedge clk);
        out_ready = 1'b0;
        drive(va);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_pre_valid", {127'b0, out_valid}, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", {127'b0, out_valid}, 0);
        chk("ar_result", out_result, 0);
        chk("ar_in_ready", {127'b0, in_ready}, 1);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_rel_ready", {127'b0, in_ready}, 1);
        chk("ar_rel_valid", {127'b0, out_valid}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/se_fu.md
# se_fu

Secure-execution functional unit for the host-CCI-P AFU. It accepts one instruction per handshake: an 8-bit opcode, two 128-bit operands with per-operand byte/encrypted flags, and a 128-bit condition word. It decrypts the operands, executes the ALU operation and returns an encrypted 128-bit result through a 2-stage valid/ready pipeline. The AFU top level feeds it from host memory read responses and writes the result back through the write channel.

## Interface
- `KEY` — default 128'h0123456789ABCDEF_FEDCBA9876543210; secret cipher key.
- `clk`  in  1 — single clock; all state on rising edge.
- `reset_n`  in  1 — asynchronous, active-low reset.
- `out_ready`  in  1 — consumer can take a result.
- `out_valid`  out  1 — `out_result` holds a valid result.
- `in_ready`  out  1 — unit can accept an instruction this cycle.
- `in_valid`  in  1 — instruction fields are valid.
- `in_cond`  in  128 — condition word, used by CMOV only.
- `in_op2_is_a_byte`  in  1 — op2 is an 8-bit value.
- `in_op2_encrypted`  in  1 — op2 is ciphertext.
- `in_op2`  in  128 — operand 2.
- `in_op1_is_a_byte`, `in_op1_encrypted`  in  1 each — same meaning for op1.
- `in_op1`  in  128 — operand 1.
- `in_inst`  in  8 — opcode.
- `out_result`  out  128 — encrypted result.

## Operation
- Cipher: encrypt(x) = decrypt(x) = x ^ KEY.
- Operand preparation, in this order:
  - If the encrypted flag is set, x = x ^ KEY.
  - If the byte flag is set, x = {120'b0, x[7:0]}.
- Opcodes (a = op1, b = op2, results are 128 bits, wrap modulo 2^128):
  - 0x00 ADD: a + b.
  - 0x01 SUB: a − b.
  - 0x02 MUL: a[63:0] × b[63:0], full 128-bit product.
  - 0x03 AND, 0x04 OR, 0x05 XOR.
  - 0x06 SHL: a << b[6:0].
  - 0x07 SHR: logical a >> b[6:0].
  - 0x08 EQ: 1 if a == b, else 0.
  - 0x09 LTU: 1 if a < b unsigned, else 0.
  - 0x0A CMOV: in_cond != 0 ? a : b. The condition word is used raw and is never decrypted.
  - Any other opcode: result 0.
- Output: out_result = raw_result ^ KEY, always encrypted regardless of the input flags.
- Pipeline stages:
  - S1 registers the prepared operands, opcode and condition.
  - S2 registers the encrypted result and drives the outputs.

## Timing
- Reset (async assert, sync release):
  - s1_valid = 0, out_valid = 0, out_result = 0, all data registers 0.
  - in_ready reads 1 while reset is asserted and after release.
- Handshakes:
  - Input is accepted on a rising edge with in_valid && in_ready.
  - Output transfers on a rising edge with out_valid && out_ready.
- s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. All three are combinational, so a result can be consumed and a new one accepted in the same cycle.
- Latency: accept at edge N → result registered at edge N+1 → out_valid high from edge N+1 when the pipe is unstalled (2 edges from input presentation to output register). Throughput is 1 instruction/cycle.
- out_ready low with both stages full: in_ready = 0. out_result and out_valid hold stable until transferred.
- in_valid while in_ready = 0: the instruction is ignored and not queued; the sender must hold it.
- S2 loads on s2_adv with s1_valid; out_valid follows s1_valid when s2_adv, else holds.
- Reset mid-operation: all in-flight instructions are discarded and out_valid drops immediately.

## Test plan
- Reset, then ADD a=5, b=3, both plaintext, out_ready=1 → out_valid one cycle after acceptance; out_result = 8 ^ KEY; subsequent cycle out_valid = 0.
- SUB with op1 = (10 ^ KEY), op1_encrypted = 1, b = 3 plaintext → out_result = 7 ^ KEY.
- Byte flag: MUL a = 0x1FF, op1_is_a_byte = 1, b = 2 → out_result = 0x1FE ^ KEY. CMOV cond = 0, a = 1, b = 2 → 2 ^ KEY; cond = 1 → 1 ^ KEY.
- Backpressure:
  - out_ready = 0, send 3 back-to-back instructions → in_ready falls after 2 accepted; the third is held by the sender.
  - Raise out_ready → results drain in order with no loss or duplication.
- Edge ops:
  - SUB 0 − 1 → all-ones ^ KEY.
  - SHL a = 1, b = 127 → (1 << 127) ^ KEY.
  - Opcode 0xFF → KEY (0 ^ KEY).
- Assert reset_n = 0 with out_valid = 1 → out_valid and out_result drop to 0 asynchronously; after release in_ready = 1.
